// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads have priority over buffered SDIO
// pixel writes, with a starvation guard that forces a write after a bounded read run.
module fb_arbiter #(
    parameter  int ADDR_W       = 17,
    parameter  int DATA_W       = 16,
    parameter  int WFIFO_DEPTH  = 8,
    parameter  int STARVE_LIMIT = 16,
    localparam int LVL_W        = $clog2(WFIFO_DEPTH) + 1,
    localparam int SC_W         = $clog2(STARVE_LIMIT + 1)
) (
    input  logic              clk_pix,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_data_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [LVL_W-1:0]  wr_level,
    output logic [SC_W-1:0]   starve_cnt
);

    localparam int               PTR_W    = $clog2(WFIFO_DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(WFIFO_DEPTH);
    localparam logic [SC_W-1:0]  SC_MAX   = SC_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_IDLE,
        GNT_READ,
        GNT_WRITE,
        GNT_FORCE
    } grant_e;

    grant_e             grant;
    logic [ADDR_W-1:0]  fifo_addr [WFIFO_DEPTH];
    logic [DATA_W-1:0]  fifo_data [WFIFO_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [1:0]         rd_pipe;

    // Ready depends only on registered occupancy, so a full FIFO refuses even when popping.
    assign wr_ready   = (wr_level != FULL_LVL);
    assign fifo_empty = (wr_level == '0);
    assign push       = wr_valid && wr_ready;

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        grant = GNT_IDLE;
        if (!fifo_empty && starve_cnt == SC_MAX) begin
            grant = GNT_FORCE;
        end else if (rd_valid) begin
            grant = GNT_READ;
        end else if (!fifo_empty) begin
            grant = GNT_WRITE;
        end
    end

    assign pop      = (grant == GNT_FORCE) || (grant == GNT_WRITE);
    assign rd_ready = (grant == GNT_READ);

    // NOTE: FIFO storage is not reset; occupancy and pointers alone define which entries are live.
    always_ff @(posedge clk_pix) begin
        if (push) begin
            fifo_addr[tail] <= wr_addr;
            fifo_data[tail] <= wr_data;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            wr_level <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   wr_level <= wr_level + 1'b1;
                2'b01:   wr_level <= wr_level - 1'b1;
                default: wr_level <= wr_level;
            endcase
        end
    end

    // Counts read wins that overtook a pending write; any write or an empty FIFO clears it.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (pop || fifo_empty) begin
            starve_cnt <= '0;
        end else if (grant == GNT_READ && starve_cnt != SC_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (grant)
                GNT_READ: begin
                    mem_en   <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                GNT_WRITE, GNT_FORCE: begin
                    mem_en    <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= fifo_addr[head];
                    mem_wdata <= fifo_data[head];
                end
                default: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // rd_pipe[0] marks the issue cycle, rd_pipe[1] the cycle mem_rdata is valid.
    always_ff @(posedge clk_pix) begin
        if (rst) begin
            rd_pipe       <= '0;
            rd_data_valid <= 1'b0;
            rd_data       <= '0;
        end else begin
            rd_pipe       <= {rd_pipe[0], grant == GNT_READ};
            rd_data_valid <= rd_pipe[1];
            if (rd_pipe[1]) rd_data <= mem_rdata;
        end
    end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Single-port framebuffer arbiter in the `clk_pix` domain. It shares one synchronous RGB565 framebuffer RAM between two requesters:
- the SDIO pixel-write path, which is buffered through an internal write FIFO;
- the display scan-out read path, which has priority, bounded by a write-starvation guard.

It sits between the SDIO pixel assembler, the RGB timing/scan-out logic and the framebuffer RAM inside `top`.

## Interface
Parameters:
- `ADDR_W`, 17, framebuffer word-address width
- `DATA_W`, 16, pixel width (RGB565)
- `WFIFO_DEPTH`, 8, write FIFO entries; power of two, ≥2
- `STARVE_LIMIT`, 16, consecutive read-won cycles with a pending write before a write is forced; ≥1

Ports:
- `clk_pix`  in  1  pixel clock; sole clock
- `rst`  in  1  synchronous, active-high reset
- `wr_valid`  in  1  write request from SDIO pixel assembler
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write pixel
- `wr_ready`  out  1  FIFO not full
- `rd_valid`  in  1  scan-out read request
- `rd_addr`  in  ADDR_W  read address
- `rd_ready`  out  1  read granted this cycle
- `rd_data_valid`  out  1  returned pixel valid
- `rd_data`  out  DATA_W  returned pixel
- `mem_en`  out  1  RAM access enable (registered)
- `mem_we`  out  1  RAM write enable (registered)
- `mem_addr`  out  ADDR_W  RAM address (registered)
- `mem_wdata`  out  DATA_W  RAM write data (registered)
- `mem_rdata`  in  DATA_W  RAM read data, valid one cycle after `mem_en` with `!mem_we`
- `wr_level`  out  $clog2(WFIFO_DEPTH)+1  FIFO occupancy
- `starve_cnt`  out  $clog2(STARVE_LIMIT+1)  starvation counter

## Operation
- Write FIFO:
  - A push occurs when `wr_valid && wr_ready`.
  - `wr_ready = (wr_level != WFIFO_DEPTH)`, combinational from registered state only. A push is never accepted when full, even if a pop happens the same cycle.
  - A push and a pop in the same cycle leave `wr_level` unchanged.
- Arbitration is decided each cycle from registered state plus `rd_valid`:
  - **FORCE_WR**: `wr_level != 0 && starve_cnt == STARVE_LIMIT`. Pop the FIFO head and issue a write; `rd_ready = 0`.
  - **READ**: otherwise, if `rd_valid`. `rd_ready = 1` and the read is issued.
  - **WRITE**: otherwise, if `wr_level != 0`. Pop and issue the write.
  - **IDLE**: none of the above. No access.
- `starve_cnt`:
  - Increments when READ wins while `wr_level != 0`.
  - Clears on any issued write or whenever `wr_level == 0`.
  - Saturates at `STARVE_LIMIT`.
- Issue registers: `mem_en`/`mem_we`/`mem_addr`/`mem_wdata` load on the edge ending the decision cycle. In an IDLE cycle `mem_en = 0` and `mem_we = 0`, and the address and data registers hold.
- Read return: a 2-stage valid pipe follows read issues. `rd_data` is a registered capture of `mem_rdata`. `rd_data_valid` is a one-cycle pulse per accepted read, in issue order.
- A write and a read are never issued in the same cycle.
- Reset:
  - FIFO is flushed (`wr_level = 0`, `wr_ready = 1`) and `starve_cnt = 0`.
  - `mem_en = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_wdata = 0`.
  - Valid pipe is cleared: `rd_data_valid = 0` and `rd_data = 0`.
  - In-flight reads are discarded; no `rd_data_valid` pulse appears for them after reset.

## Timing
- Read latency: accepted in cycle N → `mem_en` with `!mem_we` in N+1 → `mem_rdata` in N+2 → `rd_data_valid` and `rd_data` in N+3. Fixed at 3 cycles, with back-to-back throughput of 1 read per cycle.
- Write latency: pushed in cycle N → earliest pop in N+1 → `mem_we` in N+2.
- Worst-case write wait with continuous reads is `STARVE_LIMIT` read cycles, then one forced write.
- Sustained read stream: at most one stall cycle per `STARVE_LIMIT+1` cycles while writes are pending.
- `rd_ready` and `wr_ready` have no combinational path from `mem_rdata`.

## Test plan
- Reset then idle: hold `rst` for 3 cycles, then release. Required: `wr_ready = 1`, `rd_ready = 0`, `mem_en = 0`, `wr_level = 0`, `rd_data_valid = 0` for 10 cycles.
- Single write then read: push addr `0x00010`, data `0xF800`. Required:
  - `mem_we = 1`, `mem_addr = 0x00010`, `mem_wdata = 0xF800` two cycles after the push.
  - A read of `0x00010` returns `rd_data = 0xF800` exactly 3 cycles after acceptance.
- FIFO full: with `rd_valid` held high and `STARVE_LIMIT = 16`, push 9 writes back-to-back. Required: `wr_level` reaches 8, `wr_ready = 0` on the 9th attempt, and the 9th write is not accepted.
- Starvation guard: with `rd_valid` held continuously and one write pending, the write issues after exactly 16 read grants. In that cycle `rd_ready = 0` and `starve_cnt` returns to 0 in the next cycle.
- Ordering: 32 sequential reads return `rd_data_valid` pulses in address order, one per accepted read, with interleaved forced writes not reordering them.
- Reset mid-operation: assert `rst` one cycle after a read is accepted. Required: no `rd_data_valid` for that read, `wr_level = 0`, and `mem_en = 0` after the reset edge.
